// File: rtl/bnn_feature_encoder.sv
// bnn_feature_encoder: sequences four sensor channels through a req/ack
// sample port, averages 2^LOG2_AVG samples per channel, binarises each mean
// against its threshold with hysteresis, and presents the 4-bit feature
// vector on a valid/ready port.
module bnn_feature_encoder #(
    parameter int DATA_W   = 8,
    parameter int LOG2_AVG = 2,
    parameter int HYST     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cont,
    input  logic [4*DATA_W-1:0] thresh,
    output logic                sample_req,
    output logic [1:0]          ch_sel,
    input  logic                sample_ack,
    input  logic [DATA_W-1:0]   sample_data,
    output logic                feat_valid,
    input  logic                feat_ready,
    output logic [3:0]          feat_data,
    output logic                busy
);

    localparam int                ACC_W    = DATA_W + LOG2_AVG;
    localparam int                CNT_W    = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [DATA_W:0]   HYST_X   = (DATA_W+1)'(HYST);
    localparam logic [DATA_W:0]   MAX_X    = {1'b0, {DATA_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        EVAL,
        OUT
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         bits_q, bits_d;
    logic [3:0]         feat_data_q, feat_data_d;
    logic               req_q, req_d;
    logic               fvalid_q, fvalid_d;
    logic               busy_q, busy_d;

    logic [DATA_W-1:0]  thr_sel;
    logic [DATA_W-1:0]  mean;
    logic [DATA_W:0]    thr_sum;
    logic [DATA_W-1:0]  thr_hi;
    logic [DATA_W-1:0]  thr_lo;

    // Channel mean and saturating hysteresis bounds for the current channel
    always_comb begin
        thr_sel = thresh[int'(ch_q)*DATA_W +: DATA_W];
        mean    = acc_q[ACC_W-1:LOG2_AVG];
        thr_sum = {1'b0, thr_sel} + HYST_X;
        thr_hi  = (thr_sum > MAX_X) ? MAX_X[DATA_W-1:0] : thr_sum[DATA_W-1:0];
        thr_lo  = ({1'b0, thr_sel} < HYST_X) ? '0 : (thr_sel - HYST_X[DATA_W-1:0]);
    end

    // Next-state and next-output computation
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bits_d  = bits_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    ch_d    = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            REQ: begin
                if (sample_ack) begin
                    acc_d = acc_q + ACC_W'(sample_data);
                    if (cnt_q == CNT_LAST) begin
                        state_d = EVAL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EVAL: begin
                if (!bits_q[ch_q] && (mean >= thr_hi)) begin
                    bits_d[ch_q] = 1'b1;
                end else if (bits_q[ch_q] && (mean < thr_lo)) begin
                    bits_d[ch_q] = 1'b0;
                end
                acc_d = '0;
                cnt_d = '0;
                if (ch_q == 2'd3) begin
                    state_d = OUT;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    state_d = REQ;
                end
            end
            OUT: begin
                // feat_valid is always high in OUT, so ready alone completes the handshake
                if (feat_ready) begin
                    if (cont) begin
                        state_d = REQ;
                        ch_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        req_d       = (state_d == REQ);
        fvalid_d    = (state_d == OUT);
        busy_d      = (state_d != IDLE);
        feat_data_d = (state_d == OUT) ? bits_d : feat_data_q;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            bits_q      <= '0;
            feat_data_q <= '0;
            req_q       <= 1'b0;
            fvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bits_q      <= bits_d;
            feat_data_q <= feat_data_d;
            req_q       <= req_d;
            fvalid_q    <= fvalid_d;
            busy_q      <= busy_d;
        end
    end

    assign sample_req = req_q;
    assign ch_sel     = ch_q;
    assign feat_valid = fvalid_q;
    assign feat_data  = feat_data_q;
    assign busy       = busy_q;

endmodule

// File: doc/bnn_feature_encoder.md
Name: bnn_feature_encoder

Overview:
Front-end producer for the microgreen BNN classifier. Sequences four sensor channels through a request/acknowledge sample port and averages 2^LOG2_AVG samples per channel. Each channel mean is binarised against a per-channel threshold with hysteresis. The resulting 4-bit feature vector goes to the classifier's feature input through a valid/ready handshake. Bit i of the vector is channel i, matching classifier feature bit i.

Parameters:
DATA_W, 8, sample width in bits.
LOG2_AVG, 2, log2 of the number of samples averaged per channel (N = 4).
HYST, 4, hysteresis half-width in LSBs. Requirement: HYST < 2^DATA_W.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run one frame; ignored unless busy=0
cont  in  1  continuous mode; sampled at output handshake
thresh  in  4*DATA_W  per-channel thresholds; channel i in bits [i*DATA_W +: DATA_W]
sample_req  out  1  requesting a sample from channel ch_sel
ch_sel  out  2  channel being sampled
sample_ack  in  1  sample_data is valid this cycle; completes the request
sample_data  in  DATA_W  raw sample
feat_valid  out  1  feat_data is valid
feat_ready  in  1  downstream accepts feat_data
feat_data  out  4  binarised feature vector
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0 (sample_req, ch_sel, feat_valid, feat_data, busy). The accumulator, sample counter, channel index and stored feature bits are cleared.
- Reset mid-frame aborts the frame with no partial output.
- FSM states: IDLE, REQ, EVAL, OUT.
- IDLE:
  - start=1 → REQ with ch=0, acc=0, cnt=0.
- REQ:
  - sample_req=1 and ch_sel=ch.
  - Both are held stable until sample_ack; the sample port may stall indefinitely.
  - On sample_ack: acc += sample_data, captured the same cycle. acc is DATA_W+LOG2_AVG bits wide and cannot overflow.
  - If cnt == N-1, go to EVAL; otherwise cnt++ and stay in REQ.
  - sample_ack while sample_req=0 is ignored.
- EVAL (1 cycle, sample_req=0):
  - mean = acc >> LOG2_AVG (truncating).
  - thr_hi = min(thresh_i + HYST, 2^DATA_W - 1); thr_lo = max(thresh_i - HYST, 0). Both are computed without wrap.
  - If stored bit_i = 0 and mean >= thr_hi → bit_i = 1.
  - If stored bit_i = 1 and mean < thr_lo → bit_i = 0.
  - Otherwise bit_i holds.
  - Clear acc and cnt. If ch == 3 go to OUT, else ch++ and go to REQ.
- OUT:
  - feat_valid=1 and feat_data = stored bits. Both stay stable until feat_ready.
  - On feat_valid & feat_ready: if cont=1 go to REQ with ch=0, else go to IDLE.
  - feat_valid deasserts the cycle after the handshake.
- feat_data holds its last value outside OUT. Stored bits persist across frames to provide hysteresis memory; only reset clears them.
- Latency with sample_ack tied high:
  - start seen at edge k → first sample_req at cycle k+1.
  - Each channel takes N+1 cycles.
  - feat_valid rises at cycle k+1+4(N+1) = k+21 at defaults.
  - In cont mode, the next frame's sample_req follows the handshake by 1 cycle.
- start asserted while busy=1 has no effect and is not queued.
- thresh is sampled during EVAL of each channel; changing it mid-frame affects only channels not yet evaluated.

Test Plan:
1. Basic frame:
   - Stimulus: thresh all 100, ack tied high. Samples ch0 = 4×120, ch1 = 4×50, ch2 = 4×104 (exactly thr_hi), ch3 = 4×103.
   - Response: feat_data=4'b0101, feat_valid rises 21 cycles after start, ch_sel sequence 0,1,2,3.
2. Hysteresis hold/drop:
   - Stimulus: after test 1, next frame with ch0 mean 97 (≥ thr_lo=96) and ch2 mean 95, others unchanged.
   - Response: feat_data=4'b0001.
3. Backpressure:
   - Stimulus: feat_ready low for 10 cycles in OUT.
   - Response: feat_valid=1 and feat_data stable throughout, sample_req=0, start ignored; handshake then returns to IDLE with busy=0.
4. Ack stall:
   - Stimulus: sample_ack with 0–5 random wait cycles on every sample.
   - Response: sample_req and ch_sel stable while waiting; same feat_data as the no-stall run.
5. Reset mid-operation:
   - Stimulus: assert rst_n low during ch2 accumulation.
   - Response: all outputs 0 immediately (async). A following start yields a complete fresh 4-channel frame, with stored bits treated as 0.
6. Saturation and continuous mode:
   - Stimulus: thresh ch0=254 with mean 255; thresh ch1=2 with bit already set and mean 0; cont=1.
   - Response: bit0=1 (thr_hi clamped to 255); bit1 stays 1 (thr_lo clamped to 0); frames repeat back-to-back with sample_req 1 cycle after each handshake.
